// File: rtl/tc_event_logger.sv
// Timestamps terminal-count events with a sequence number and queues them in a show-ahead FIFO.
// Define TC_EDGE_DETECT_EN to trigger events on rising edges of tc_in instead of on every high cycle.
module tc_event_logger #(
  parameter int unsigned TS_WIDTH  = 16,
  parameter int unsigned SEQ_WIDTH = 16,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tc_in,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_WIDTH-1:0]      out_timestamp,
  output logic [SEQ_WIDTH-1:0]     out_seq,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [SEQ_WIDTH-1:0]     event_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = TS_WIDTH + SEQ_WIDTH;

  logic [TS_WIDTH-1:0]  ts_q;
  logic [SEQ_WIDTH-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic [EW-1:0]        mem_q [DEPTH];
  logic                 evt, pop, push, full;

`ifdef TC_EDGE_DETECT_EN
  // Resets high so a tc_in already asserted at reset release is not an event.
  logic tc_prev_q;

  always_ff @(posedge clk) begin
    if (!reset) tc_prev_q <= 1'b1;
    else        tc_prev_q <= tc_in;
  end

  assign evt = tc_in & ~tc_prev_q;
`else
  assign evt = tc_in;
`endif

  assign out_valid = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts the event when the head is popped in the same cycle.
  assign push      = evt & ~clear & (~full | pop);

  always_comb begin
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (clear) begin
      cnt_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (evt) begin
        cnt_d = cnt_q + SEQ_WIDTH'(1);
        if (!push) ovf_d = 1'b1;
      end
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q    <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_q + TS_WIDTH'(1);
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wptr_q] <= {ts_q, cnt_q};
  end

  assign out_timestamp = out_valid ? mem_q[rptr_q][EW-1:SEQ_WIDTH] : '0;
  assign out_seq       = out_valid ? mem_q[rptr_q][SEQ_WIDTH-1:0]  : '0;
  assign fifo_level    = level_q;
  assign overflow      = ovf_q;
  assign event_count   = cnt_q;

endmodule

// File: tb/tb_tc_event_logger.sv
// Self-checking bench for tc_event_logger: scoreboard queue of expected entries plus a vector table.
// Follows TC_EDGE_DETECT_EN the same way the design does.
module tb_tc_event_logger;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, tc_in, clear, out_ready;
  logic        out_valid, overflow;
  logic [15:0] out_timestamp, out_seq, event_count;
  logic [3:0]  fifo_level;

  tc_event_logger #(.TS_WIDTH(16), .SEQ_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .tc_in        (tc_in),
    .clear        (clear),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_timestamp(out_timestamp),
    .out_seq      (out_seq),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tc;
    int clr;
    int rdy;
    int level;
    int ovf;
    int cnt;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [15:0] m_ts = '0;
  logic [15:0] m_cnt = '0;
  logic        m_ovf = 1'b0;
  logic        m_hist = 1'b1;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model by one edge using the currently driven inputs, then compare.
  task automatic tick();
    logic        evt;
    logic [31:0] head;
    if (!reset) begin
      m_ts   = '0;
      m_cnt  = '0;
      m_ovf  = 1'b0;
      m_hist = 1'b1;
      sb_q.delete();
    end else begin
`ifdef TC_EDGE_DETECT_EN
      evt = tc_in & ~m_hist;
`else
      evt = tc_in;
`endif
      m_hist = tc_in;
      if (clear) begin
        sb_q.delete();
        m_cnt = '0;
        m_ovf = 1'b0;
      end else begin
        if (out_ready && sb_q.size() > 0) begin
          head = sb_q.pop_front();
          chk("pop_timestamp", 32'(out_timestamp), 32'(head[31:16]));
          chk("pop_seq", 32'(out_seq), 32'(head[15:0]));
        end
        if (evt) begin
          if (sb_q.size() < DEPTH) sb_q.push_back({m_ts, m_cnt});
          else m_ovf = 1'b1;
          m_cnt = m_cnt + 16'd1;
        end
      end
      m_ts = m_ts + 16'd1;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    chk("fifo_level", 32'(fifo_level), 32'(sb_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("event_count", 32'(event_count), 32'(m_cnt));
    if (!out_valid) begin
      chk("idle_timestamp", 32'(out_timestamp), 32'd0);
      chk("idle_seq", 32'(out_seq), 32'd0);
    end
  endtask

  task automatic drive(input logic t, input logic c, input logic r);
    tc_in     = t;
    clear     = c;
    out_ready = r;
    tick();
  endtask

  // Isolated single-cycle pulse followed by an idle cycle, so both event modes agree.
  task automatic pulse();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int          guard;
    int          n_pop;
    logic [15:0] prev_ts;

    reset = 1'b0; tc_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    // Cycles with ts = 0..3, then pulse while ts = 4.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("ts_after_reset", 32'(out_timestamp), 32'h4);
    chk("seq_after_reset", 32'(out_seq), 32'h0);

    // Empty the FIFO, then pulse exactly when ts = 0x0010.
    drive(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (m_ts != 16'h0010 && guard < 100) begin
      drive(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_ts_0x10", 32'(guard < 100), 32'd1);
    drive(1'b1, 1'b0, 1'b0);
    chk("pulse_timestamp", 32'(out_timestamp), 32'h0010);
    chk("pulse_seq", 32'(out_seq), 32'h0);
    chk("pulse_level", 32'(fifo_level), 32'd1);
    chk("pulse_count", 32'(event_count), 32'd1);
    drive(1'b0, 1'b0, 1'b0);

    // Table: clear, ten isolated pulses into an unread FIFO, then a full drain.
    tbl.push_back('{tc: 0, clr: 1, rdy: 0, level: 0, ovf: 0, cnt: 0});
    for (int i = 0; i < 10; i++) begin
      tbl.push_back('{tc: 1, clr: 0, rdy: 0, level: (i < 8) ? i + 1 : 8, ovf: (i >= 8) ? 1 : 0,
                      cnt: i + 1});
      tbl.push_back('{tc: 0, clr: 0, rdy: 0, level: (i < 8) ? i + 1 : 8, ovf: (i >= 8) ? 1 : 0,
                      cnt: i + 1});
    end
    for (int i = 0; i < 8; i++)
      tbl.push_back('{tc: 0, clr: 0, rdy: 1, level: 7 - i, ovf: 1, cnt: 10});
    tbl.push_back('{tc: 0, clr: 0, rdy: 1, level: 0, ovf: 1, cnt: 10});
    foreach (tbl[i]) begin
      drive(tbl[i].tc[0], tbl[i].clr[0], tbl[i].rdy[0]);
      chk("tbl_level", 32'(fifo_level), 32'(tbl[i].level));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
      chk("tbl_count", 32'(event_count), 32'(tbl[i].cnt));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].level != 0));
    end

    // Full FIFO with event and pop in the same cycle.
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) pulse();
    chk("full_level", 32'(fifo_level), 32'd8);
    drive(1'b1, 1'b0, 1'b1);
    chk("fullpop_level", 32'(fifo_level), 32'd8);
    chk("fullpop_overflow", 32'(overflow), 32'd0);
    chk("fullpop_count", 32'(event_count), 32'd9);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1);
    chk("fullpop_tail_seq", 32'(out_seq), 32'd8);
    chk("fullpop_tail_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b1);

    // tc_in held high for four cycles.
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
`ifdef TC_EDGE_DETECT_EN
    chk("hold_count", 32'(event_count), 32'd1);
`else
    chk("hold_count", 32'(event_count), 32'd4);
`endif
    n_pop = 0;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      if (out_valid) begin
        if (n_pop > 0) chk("hold_ts_step", 32'(out_timestamp - prev_ts), 32'd1);
        prev_ts = out_timestamp;
        n_pop++;
      end
      drive(1'b0, 1'b0, 1'b1);
    end

    // Three queued entries with overflow set, then clear coinciding with a pulse.
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) pulse();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
    chk("pre_clear_level", 32'(fifo_level), 32'd3);
    chk("pre_clear_overflow", 32'(overflow), 32'd1);
    drive(1'b1, 1'b1, 1'b0);
    chk("clear_level", 32'(fifo_level), 32'd0);
    chk("clear_valid", 32'(out_valid), 32'd0);
    chk("clear_overflow", 32'(overflow), 32'd0);
    chk("clear_count", 32'(event_count), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    // ts keeps running across clear; the scoreboard timestamp checks that on the drain.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) pulse();
    drive(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    chk("reset_drain_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    pulse();
    drive(1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
